alu_result_stage: RTL and testbench

//   Registered output stage directly downstream of the 32-bit ALU result mux array (one 16:1 mux per bit).
//   - Captures the selected result, the 4-bit op select, and the raw carry/overflow.
//   - Derives status flags and presents them through a valid/ready handshake.
//   - A 2-entry skid buffer gives full throughput while keeping in_ready registered.

---
 rtl/alu_result_stage.sv | 160 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : Registered output stage behind the 32-bit ALU result mux
//               array. Captures result, op select and raw carry/overflow,
//               derives status flags at capture time, and presents them
//               through a valid/ready handshake. A 2-entry skid buffer
//               (main + skid) sustains one transfer per cycle while keeping
//               in_ready a pure flop output.
// Optional    : ALU_RES_STICKY_EN -- adds sticky_ovf / sticky_clr, an
//               accumulated overflow flag over all accepted entries.
// Ports       : clk, reset_n (sync, active-low)
//               in_valid/in_ready, in_result, in_sel, in_cout, in_ovf
//               out_valid/out_ready, out_result, out_sel, out_zero,
//               out_neg, out_cout, out_ovf
//               sticky_ovf (out), sticky_clr (in)  [ALU_RES_STICKY_EN]
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_cout,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_cout,
    output logic             out_ovf
`ifdef ALU_RES_STICKY_EN
    ,
    output logic             sticky_ovf,
    input  logic             sticky_clr
`endif
);

    // Entry layout: {result, sel, zero, neg, cout, ovf}
    localparam int ENTRY_W = WIDTH + SEL_W + 4;

    localparam logic [1:0] ST_EMPTY = 2'd0;  // nothing held
    localparam logic [1:0] ST_ONE   = 2'd1;  // main valid, skid empty
    localparam logic [1:0] ST_FULL  = 2'd2;  // main and skid valid

    logic [1:0]         state_q, state_d;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic               in_ready_q, in_ready_d;

    logic               w_arith;
    logic               w_in_ovf_masked;
    logic [ENTRY_W-1:0] w_in_entry;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_out_valid;

    // Top select bit splits arithmetic ops (0-7) from logic/shift ops (8-15);
    // carry and overflow are meaningless for the latter and are forced low.
    assign w_arith         = ~in_sel[SEL_W-1];
    assign w_in_ovf_masked = w_arith & in_ovf;
    assign w_in_entry      = {in_result, in_sel, ~|in_result, in_result[WIDTH-1],
                              w_arith & in_cout, w_in_ovf_masked};

    assign w_out_valid = (state_q != ST_EMPTY);
    assign w_in_xfer   = in_valid & in_ready_q;
    assign w_out_xfer  = w_out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    main_d  = w_in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    main_d = w_in_entry;
                end else if (w_in_xfer) begin
                    skid_d  = w_in_entry;
                    state_d = ST_FULL;
                end else if (w_out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no input can arrive this cycle.
                if (w_out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Registered ready: derived from the next state so it is a flop output.
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = w_out_valid;
    assign out_result = main_q[ENTRY_W-1 -: WIDTH];
    assign out_sel    = main_q[4 +: SEL_W];
    assign out_zero   = main_q[3];
    assign out_neg    = main_q[2];
    assign out_cout   = main_q[1];
    assign out_ovf    = main_q[0];

`ifdef ALU_RES_STICKY_EN
    logic sticky_q, sticky_d;

    // A set in the same cycle as a clear wins, so no overflow is ever lost.
    always_comb begin
        sticky_d = sticky_q;
        if (w_in_xfer && w_in_ovf_masked) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench for alu_result_stage. A queue-based FIFO
//               model of capacity two predicts out_valid, in_ready and the
//               head entry; flags are computed from the op rules directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_sel;
    logic        in_cout;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_sel;
    logic        out_zero;
    logic        out_neg;
    logic        out_cout;
    logic        out_ovf;
    logic        sticky_ovf;
    logic        sticky_clr;

    int checks;
    int errors;

    logic [39:0] mq[$];
    logic        exp_sticky;

    alu_result_stage #(.WIDTH(32), .SEL_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .in_cout    (in_cout),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf)
`ifdef ALU_RES_STICKY_EN
        ,
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr)
`endif
    );

`ifndef ALU_RES_STICKY_EN
    assign sticky_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [31:0] res, input logic [3:0] sel,
                                       input logic c, input logic o);
        logic arith;
        arith = (sel < 4'd8);
        return {res, sel, (res == 32'd0), (res >= 32'h8000_0000), arith & c, arith & o};
    endfunction

    function automatic logic [39:0] obs();
        return {out_result, out_sel, out_zero, out_neg, out_cout, out_ovf};
    endfunction

    // One clock: drive inputs, advance model by the predicted transfers,
    // and return at the following negedge ready for checking.
    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] sel,
                         input logic c, input logic o, input logic rdy, input logic clr);
        logic in_x, out_x;
        logic [39:0] e;
        in_valid   = v;
        in_result  = res;
        in_sel     = sel;
        in_cout    = c;
        in_ovf     = o;
        out_ready  = rdy;
        sticky_clr = clr;
        e     = mk(res, sel, c, o);
        in_x  = v && (mq.size() < 2);
        out_x = (mq.size() > 0) && rdy;
        @(posedge clk);
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back(e);
        if (in_x && e[0]) exp_sticky = 1'b1;
        else if (clr) exp_sticky = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        sticky_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        exp_sticky = 1'b0;
    endtask

    task automatic test_reset();
        // Load some state first so reset has something to discard.
        drive(1, 32'h1234_5678, 4'h1, 1, 1, 0, 0);
        drive(1, 32'h9abc_def0, 4'h3, 1, 1, 0, 0);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, out_valid);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready cyc%0d: got %b want 1", i, in_ready);
            end
            checks++;
            if (obs() !== 40'd0) begin
                errors++; $display("FAIL reset_data cyc%0d: got %h want 0", i, obs());
            end
        end
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_sticky: got %b want 0", sticky_ovf);
        end
        reset_n  = 1'b1;
        in_valid = 1'b0;
        mq.delete();
        exp_sticky = 1'b0;
    endtask

    task automatic test_single_op();
        drive(1, 32'h0000_0000, 4'h2, 1, 0, 1, 0);
        checks++;
        if ({out_valid, out_zero, out_neg, out_cout, out_ovf} !== 5'b11010) begin
            errors++; $display("FAIL single_op_flags: got v,z,n,c,o=%b want 11010",
                               {out_valid, out_zero, out_neg, out_cout, out_ovf});
        end
        checks++;
        if (out_sel !== 4'h2 || out_result !== 32'd0) begin
            errors++; $display("FAIL single_op_data: got %h/%h want 0/2", out_result, out_sel);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_op_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_masking();
        drive(1, 32'h8000_0001, 4'hA, 1, 1, 1, 0);
        checks++;
        if ({out_valid, out_neg, out_zero, out_cout, out_ovf} !== 5'b11000) begin
            errors++; $display("FAIL masking_flags: got v,n,z,c,o=%b want 11000",
                               {out_valid, out_neg, out_zero, out_cout, out_ovf});
        end
        drive(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        drive(1, 32'h1, 4'h0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_after_a: got v=%b r=%h rdy=%b want 1/1/1",
                               out_valid, out_result, in_ready);
        end
        drive(1, 32'h2, 4'h0, 0, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready);
        end
        drive(1, 32'h3, 4'h0, 0, 0, 0, 0);
        checks++;
        if (out_result !== 32'h1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold_c: got r=%h rdy=%b want 1/0", out_result, in_ready);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h2 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_b: got v=%b r=%h rdy=%b want 1/2/1",
                               out_valid, out_result, in_ready);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got %b want 0 (C must not appear)", out_valid);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
            end
            drive(1, i[31:0] + 32'd100, 4'h0, 0, 0, 1, 0);
            checks++;
            if (out_valid !== 1'b1 || out_result !== i[31:0] + 32'd100) begin
                errors++; $display("FAIL stream_data[%0d]: got v=%b r=%h want 1/%h",
                                   i, out_valid, out_result, i[31:0] + 32'd100);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            drive($urandom_range(0, 1), r, $urandom_range(0, 15), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0, 1'b0);
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got v=%b rdy=%b want %b/%b",
                                   i, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                checks++;
                if (obs() !== mq[0]) begin
                    errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, obs(), mq[0]);
                end
            end
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);
    endtask

`ifdef ALU_RES_STICKY_EN
    task automatic test_sticky();
        do_reset();
        drive(1, 32'h5, 4'h1, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++; $display("FAIL sticky_set: got %b want 1", sticky_ovf);
        end
        drive(1, 32'h6, 4'h1, 0, 1, 1, 1);
        checks++;
        if (sticky_ovf !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins: got %b want 1", sticky_ovf);
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (sticky_ovf !== 1'b0) begin
            errors++; $display("FAIL sticky_clear: got %b want 0", sticky_ovf);
        end
        drive(1, 32'h7, 4'hB, 0, 1, 1, 0);
        checks++;
        if (sticky_ovf !== exp_sticky) begin
            errors++; $display("FAIL sticky_logic_op: got %b want %b", sticky_ovf, exp_sticky);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        exp_sticky = 1'b0;
        in_valid   = 1'b0;
        in_result  = '0;
        in_sel     = '0;
        in_cout    = 1'b0;
        in_ovf     = 1'b0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        reset_n    = 1'b0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_single_op();
        test_masking();
        test_backpressure();
        test_streaming();
        test_random();
`ifdef ALU_RES_STICKY_EN
        test_sticky();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
